// File: rtl/fetch_redirect_ctrl_pkg.sv
// Types shared by the fetch redirect controller and the instruction fetch unit:
// the next-PC select encoding, the controller state and the pending-redirect record.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package fetch_redirect_ctrl_pkg;

  // Address width of a held redirect target; this is the build-wide fetch address width.
  localparam int PEND_ADDR_W = `INST_ADDR_WIDTH;

  // Next-PC source selected by the IFU. The encoding is shared with the IFU mux.
  typedef enum logic [1:0] {
    sb          = 2'd0,
    uj          = 2'd1,
    jalr        = 2'd2,
    pc_plus_4_t = 2'd3
  } next_pc_t;

  // RUN: normal fetch. HOLD: a redirect is parked while fetch is frozen.
  // SQUASH: wrong-path bundles are being dropped after a redirect.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  // A redirect that could not be applied yet because the backend was stalled.
  typedef struct packed {
    logic                   valid;
    next_pc_t               kind;
    logic [PEND_ADDR_W-1:0] target;
  } pend_redirect_t;

  // Execute-stage redirects are either JALR or a taken conditional branch.
  function automatic next_pc_t ex_kind(input logic is_jalr);
    return is_jalr ? jalr : sb;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates execute and decode redirects against the
// backend stall, parks a redirect that arrives while fetch is frozen, and squashes
// the wrong-path bundles that follow every applied redirect.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
  parameter int FETCH_WIDTH     = `FETCH_WIDTH,
  parameter int SQUASH_CYCLES   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_br_valid,
  input  logic                       ex_br_is_jalr,
  input  logic [INST_ADDR_WIDTH-1:0] ex_br_target,
  input  logic                       dec_jal_valid,
  input  logic [INST_ADDR_WIDTH-1:0] dec_jal_target,
  input  logic                       backend_stall,
  output next_pc_t                   next_pc_sel,
  output logic [INST_ADDR_WIDTH-1:0] SB_Type_addr,
  output logic [INST_ADDR_WIDTH-1:0] UJ_Type_addr,
  output logic [INST_ADDR_WIDTH-1:0] JALR_Type_addr,
  output logic                       ifu_stall,
  output logic                       fetch_valid,
  output logic                       redirect_taken
);

  // The pending record carries a package-wide address width; it must match the ports.
  if (INST_ADDR_WIDTH != PEND_ADDR_W) begin : g_bad_addr_width
    $error("INST_ADDR_WIDTH must equal the package address width");
  end
  // A bundle is squashed as a whole, so its width only has to be sane.
  if (FETCH_WIDTH < 1) begin : g_bad_fetch_width
    $error("FETCH_WIDTH must be at least 1");
  end
  if (SQUASH_CYCLES < 0) begin : g_bad_squash
    $error("SQUASH_CYCLES must not be negative");
  end

  localparam int CNT_W = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SQUASH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_state_t               state_q;
  fetch_state_t               state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       pend_valid_q;
  next_pc_t                   pend_kind_q;
  logic [INST_ADDR_WIDTH-1:0] pend_target_q;
  pend_redirect_t             pend_d;
  logic                       pend_load;

  logic                       win_valid;
  next_pc_t                   win_kind;
  logic [INST_ADDR_WIDTH-1:0] win_target;
  logic                       apply;

  // Pick the redirect that owns this cycle: execute always wins because it is the
  // older instruction; a parked redirect comes next; decode JAL only counts in RUN.
  always_comb begin
    win_valid  = 1'b0;
    win_kind   = pc_plus_4_t;
    win_target = '0;
    if (ex_br_valid) begin
      win_valid  = 1'b1;
      win_kind   = ex_kind(ex_br_is_jalr);
      win_target = ex_br_target;
    end else begin
      unique case (state_q)
        HOLD: begin
          win_valid  = pend_valid_q;
          win_kind   = pend_kind_q;
          win_target = pend_target_q;
        end
        RUN: begin
          if (dec_jal_valid) begin
            win_valid  = 1'b1;
            win_kind   = uj;
            win_target = dec_jal_target;
          end
        end
        default: begin
          // In SQUASH decode is looking at the wrong path, so its JAL is ignored.
        end
      endcase
    end
    apply     = win_valid && !backend_stall;
    pend_load = win_valid && backend_stall;
  end

  // Drive the IFU. A redirect goes out on exactly one address port; a redirect that
  // has to be parked also invalidates the current bundle, which is about to be replaced.
  always_comb begin
    next_pc_sel    = pc_plus_4_t;
    SB_Type_addr   = '0;
    UJ_Type_addr   = '0;
    JALR_Type_addr = '0;
    redirect_taken = 1'b0;
    ifu_stall      = backend_stall;
    fetch_valid    = (state_q == RUN) && !pend_load;
    if (apply) begin
      next_pc_sel    = win_kind;
      redirect_taken = 1'b1;
      unique case (win_kind)
        sb:      SB_Type_addr   = win_target;
        uj:      UJ_Type_addr   = win_target;
        jalr:    JALR_Type_addr = win_target;
        default: begin
        end
      endcase
    end
  end

  // Next state, squash counter and pending record.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = '{valid: pend_valid_q, kind: pend_kind_q, target: pend_target_q};
    if (apply) begin
      pend_d.valid = 1'b0;
      if (SQUASH_CYCLES == 0) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        state_d = SQUASH;
        cnt_d   = CNT_LOAD;
      end
    end else if (pend_load) begin
      // A newer execute redirect replaces whatever is parked; decode cannot reach here
      // from HOLD or SQUASH because the arbitration above already filtered it.
      pend_d  = '{valid: 1'b1, kind: win_kind, target: win_target};
      state_d = HOLD;
    end else if (state_q == SQUASH && !backend_stall) begin
      // Only cycles where a bundle actually moves count toward the squash.
      if (cnt_q <= CNT_ONE) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Control state, asynchronously reset so a flush can land mid-HOLD or mid-SQUASH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_d.valid;
    end
  end

  // Pending payload; only meaningful while pend_valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_kind_q   <= pend_d.kind;
      pend_target_q <= pend_d.target;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: three instances (SQUASH_CYCLES 0, 1, 2) share stimulus;
// directed scenarios check fixed values, a random run checks against a reference model.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_br_valid, ex_br_is_jalr, dec_jal_valid, backend_stall;
  logic [AW-1:0] ex_br_target, dec_jal_target;

  logic [1:0]    sel [NI];
  logic [AW-1:0] sba [NI];
  logic [AW-1:0] uja [NI];
  logic [AW-1:0] jra [NI];
  logic          ist [NI];
  logic          fv  [NI];
  logic          rt  [NI];

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, a parked redirect and the count of bundles still to drop.
  bit            m_pv   [NI];
  logic [1:0]    m_pk   [NI];
  logic [AW-1:0] m_pt   [NI];
  int            m_left [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    next_pc_t      s_w;
    logic [AW-1:0] sb_w, uj_w, jr_w;
    logic          ist_w, fv_w, rt_w;
    fetch_redirect_ctrl #(
      .INST_ADDR_WIDTH(AW),
      .FETCH_WIDTH    (4),
      .SQUASH_CYCLES  (g)
    ) dut (
      .clk           (clk),
      .reset         (reset),
      .ex_br_valid   (ex_br_valid),
      .ex_br_is_jalr (ex_br_is_jalr),
      .ex_br_target  (ex_br_target),
      .dec_jal_valid (dec_jal_valid),
      .dec_jal_target(dec_jal_target),
      .backend_stall (backend_stall),
      .next_pc_sel   (s_w),
      .SB_Type_addr  (sb_w),
      .UJ_Type_addr  (uj_w),
      .JALR_Type_addr(jr_w),
      .ifu_stall     (ist_w),
      .fetch_valid   (fv_w),
      .redirect_taken(rt_w)
    );
    assign sel[g] = s_w;
    assign sba[g] = sb_w;
    assign uja[g] = uj_w;
    assign jra[g] = jr_w;
    assign ist[g] = ist_w;
    assign fv[g]  = fv_w;
    assign rt[g]  = rt_w;
  end

  task automatic drive(input logic e, input logic j, input logic [AW-1:0] et,
                       input logic d, input logic [AW-1:0] dt, input logic s);
    @(negedge clk);
    ex_br_valid    = e;
    ex_br_is_jalr  = j;
    ex_br_target   = et;
    dec_jal_valid  = d;
    dec_jal_target = dt;
    backend_stall  = s;
    #1;
  endtask

  task automatic idle(input logic s);
    drive(1'b0, 1'b0, '0, 1'b0, '0, s);
  endtask

  task automatic do_reset;
    @(negedge clk);
    ex_br_valid = 0; ex_br_is_jalr = 0; ex_br_target = '0;
    dec_jal_valid = 0; dec_jal_target = '0; backend_stall = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_pv[i] = 0; m_pk[i] = 2'(pc_plus_4_t); m_pt[i] = '0; m_left[i] = 0;
    end
  endtask

  task automatic test_reset;
    ex_br_valid = 0; ex_br_is_jalr = 0; ex_br_target = '0;
    dec_jal_valid = 0; dec_jal_target = '0; backend_stall = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({sel[i], sba[i], uja[i], jra[i], rt[i], ist[i], fv[i]} !==
          {2'(pc_plus_4_t), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_defaults dut%0d got sel=%0d sb=%h uj=%h jr=%h rt=%b ist=%b fv=%b want sel=3 addr=0 rt=0 ist=0 fv=1",
                 i, sel[i], sba[i], uja[i], jra[i], rt[i], ist[i], fv[i]);
      end
    end
  endtask

  task automatic test_branch;
    do_reset();
    drive(1'b1, 1'b0, 32'h40, 1'b0, '0, 1'b0);
    checks++;
    if ({sel[1], sba[1], uja[1], jra[1], rt[1]} !== {2'(sb), 32'h40, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL branch_apply got sel=%0d sb=%h uj=%h jr=%h rt=%b want sel=0 sb=40 uj=0 jr=0 rt=1",
               sel[1], sba[1], uja[1], jra[1], rt[1]);
    end
    idle(1'b0);
    checks++;
    if ({fv[1], rt[1]} !== 2'b00) begin
      errors++;
      $display("FAIL branch_squash got fv=%b rt=%b want fv=0 rt=0", fv[1], rt[1]);
    end
    checks++;
    if (fv[0] !== 1'b1) begin
      errors++;
      $display("FAIL branch_nosquash got fv=%b want 1", fv[0]);
    end
    idle(1'b0);
    checks++;
    if (fv[1] !== 1'b1) begin
      errors++;
      $display("FAIL branch_resume got fv=%b want 1", fv[1]);
    end
  endtask

  task automatic test_priority;
    do_reset();
    drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    checks++;
    if ({sel[1], sba[1], uja[1], jra[1], rt[1]} !== {2'(jalr), 32'h0, 32'h0, 32'h100, 1'b1}) begin
      errors++;
      $display("FAIL prio_jalr got sel=%0d sb=%h uj=%h jr=%h rt=%b want sel=2 sb=0 uj=0 jr=100 rt=1",
               sel[1], sba[1], uja[1], jra[1], rt[1]);
    end
    idle(1'b0);
    idle(1'b0);
    checks++;
    if ({sel[1], uja[1], rt[1], fv[1]} !== {2'(pc_plus_4_t), 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL prio_jal_dropped got sel=%0d uj=%h rt=%b fv=%b want sel=3 uj=0 rt=0 fv=1",
               sel[1], uja[1], rt[1], fv[1]);
    end
  endtask

  task automatic test_stalled_jal;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b1);
      checks++;
      if ({ist[1], fv[1], rt[1]} !== 3'b100) begin
        errors++;
        $display("FAIL jal_stall_c%0d got ist=%b fv=%b rt=%b want ist=1 fv=0 rt=0", c, ist[1], fv[1], rt[1]);
      end
    end
    idle(1'b0);
    checks++;
    if ({sel[1], uja[1], rt[1]} !== {2'(uj), 32'h200, 1'b1}) begin
      errors++;
      $display("FAIL jal_release got sel=%0d uj=%h rt=%b want sel=1 uj=200 rt=1", sel[1], uja[1], rt[1]);
    end
  endtask

  task automatic test_hold_overwrite;
    int pulses;
    do_reset();
    pulses = 0;
    drive(1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b1);
    pulses += int'(rt[1]);
    drive(1'b1, 1'b0, 32'h300, 1'b0, '0, 1'b1);
    pulses += int'(rt[1]);
    idle(1'b1);
    pulses += int'(rt[1]);
    idle(1'b0);
    pulses += int'(rt[1]);
    checks++;
    if ({sel[1], sba[1], uja[1], rt[1]} !== {2'(sb), 32'h300, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL hold_overwrite got sel=%0d sb=%h uj=%h rt=%b want sel=0 sb=300 uj=0 rt=1",
               sel[1], sba[1], uja[1], rt[1]);
    end
    for (int c = 0; c < 3; c++) begin
      idle(1'b0);
      pulses += int'(rt[1]);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_one_pulse got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_squash_stall;
    do_reset();
    drive(1'b1, 1'b0, 32'h40, 1'b0, '0, 1'b0);
    checks++;
    if (rt[2] !== 1'b1) begin
      errors++;
      $display("FAIL sq2_apply got rt=%b want 1", rt[2]);
    end
    for (int c = 0; c < 2; c++) begin
      idle(1'b1);
      checks++;
      if ({fv[2], ist[2]} !== 2'b01) begin
        errors++;
        $display("FAIL sq2_stalled_c%0d got fv=%b ist=%b want fv=0 ist=1", c, fv[2], ist[2]);
      end
    end
    for (int c = 0; c < 2; c++) begin
      idle(1'b0);
      checks++;
      if (fv[2] !== 1'b0) begin
        errors++;
        $display("FAIL sq2_drop_c%0d got fv=%b want 0", c, fv[2]);
      end
      checks++;
      if (fv[1] !== (c == 0 ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL sq1_drop_c%0d got fv=%b want %b", c, fv[1], (c == 0 ? 1'b0 : 1'b1));
      end
    end
    idle(1'b0);
    checks++;
    if (fv[2] !== 1'b1) begin
      errors++;
      $display("FAIL sq2_resume got fv=%b want 1", fv[2]);
    end
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 32'h500, 1'b1);
    idle(1'b1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({sel[i], uja[i], rt[i], fv[i], ist[i]} !== {2'(pc_plus_4_t), 32'h0, 1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL rst_hold_now dut%0d got sel=%0d uj=%h rt=%b fv=%b ist=%b want sel=3 uj=0 rt=0 fv=1 ist=1",
                 i, sel[i], uja[i], rt[i], fv[i], ist[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle(1'b0);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({sel[i], uja[i], rt[i], fv[i]} !== {2'(pc_plus_4_t), 32'h0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL rst_hold_after_c%0d dut%0d got sel=%0d uj=%h rt=%b fv=%b want sel=3 uj=0 rt=0 fv=1",
                   c, i, sel[i], uja[i], rt[i], fv[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic          e, j, d, s, hold, sqz, have;
    logic [AW-1:0] et, dt, t;
    logic [1:0]    k;
    logic [3*AW+5:0] got, exp;
    logic [1:0]    e_sel;
    logic [AW-1:0] e_sb, e_uj, e_jr;
    logic          e_rt, e_ist, e_fv;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      e  = ($urandom_range(0, 4) == 0);
      j  = 1'($urandom_range(0, 1));
      et = $urandom() & 32'hFFFF_FFFC;
      d  = ($urandom_range(0, 3) == 0);
      dt = $urandom() & 32'hFFFF_FFFC;
      s  = ($urandom_range(0, 2) == 0);
      drive(e, j, et, d, dt, s);
      for (int i = 0; i < NI; i++) begin
        hold = m_pv[i];
        sqz  = !hold && (m_left[i] > 0);
        have = 1'b0; k = 2'(pc_plus_4_t); t = '0;
        if (e) begin
          have = 1'b1; k = j ? 2'(jalr) : 2'(sb); t = et;
        end else if (hold) begin
          have = 1'b1; k = m_pk[i]; t = m_pt[i];
        end else if (d && !sqz) begin
          have = 1'b1; k = 2'(uj); t = dt;
        end
        e_sel = 2'(pc_plus_4_t); e_sb = '0; e_uj = '0; e_jr = '0; e_rt = 1'b0;
        e_ist = s;
        e_fv  = !hold && !sqz && !(have && s);
        if (have && !s) begin
          e_sel = k; e_rt = 1'b1;
          if (k == 2'(sb)) e_sb = t;
          else if (k == 2'(uj)) e_uj = t;
          else e_jr = t;
        end
        exp = {e_sel, e_sb, e_uj, e_jr, e_rt, e_ist, e_fv};
        got = {sel[i], sba[i], uja[i], jra[i], rt[i], ist[i], fv[i]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random c%0d dut%0d got %h want %h", c, i, got, exp);
        end
        if (have && !s) begin
          m_pv[i] = 0; m_left[i] = i;
        end else if (have) begin
          m_pv[i] = 1; m_pk[i] = k; m_pt[i] = t;
        end else if (sqz && !s) begin
          m_left[i] = m_left[i] - 1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_stalled_jal();
    test_hold_overwrite();
    test_squash_stall();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencing controller in front of the instruction fetch unit. It merges redirect requests from decode (JAL) and execute (taken branch, JALR) with the backend stall. It drives the IFU's next-PC select, target addresses and stall, and holds a redirect that arrives while fetch is frozen so it is never lost. After every applied redirect it squashes the wrong-path fetch bundles in flight toward decode.

## Interface
- INST_ADDR_WIDTH, `INST_ADDR_WIDTH`, instruction address width
- FETCH_WIDTH, `FETCH_WIDTH`, instructions per fetch bundle (informational; bundle is squashed as a whole)
- SQUASH_CYCLES, 1, bundles invalidated after a redirect; 0 disables squash

- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high
- ex_br_valid  in  1  execute resolved a taken redirect this cycle
- ex_br_is_jalr  in  1  qualifies ex_br_valid: 1 = JALR, 0 = conditional branch
- ex_br_target  in  INST_ADDR_WIDTH  execute redirect target
- dec_jal_valid  in  1  decode found a JAL in a valid bundle
- dec_jal_target  in  INST_ADDR_WIDTH  JAL target
- backend_stall  in  1  downstream cannot accept a bundle
- next_pc_sel  out  next_pc_t  to IFU select
- SB_Type_addr, UJ_Type_addr, JALR_Type_addr  out  INST_ADDR_WIDTH each  to IFU targets
- ifu_stall  out  1  to IFU stall
- fetch_valid  out  1  current IFU bundle is valid for decode
- redirect_taken  out  1  one-cycle pulse in the cycle the IFU loads a redirect target

## Operation
- States: RUN, HOLD (redirect pending, fetch frozen), SQUASH (dropping wrong-path bundles).
- Priority: execute redirect over decode JAL, because the execute request is older. A lower-priority request in the same cycle is dropped, not queued.
- Outputs are combinational from the state, the pending registers and the live inputs. The IFU samples them on the next posedge.
- Default outputs: next_pc_sel=pc_plus_4_t, all three addresses 0, ifu_stall=backend_stall, redirect_taken=0.
- RUN, winning request present, backend_stall=0:
  - Drive sb, uj or jalr with the target on the matching address port. All other address ports stay 0.
  - redirect_taken=1.
  - Next state: SQUASH with counter=SQUASH_CYCLES, or RUN if SQUASH_CYCLES=0.
- RUN, winning request present, backend_stall=1:
  - Capture kind and target into the pending registers. Go to HOLD. ifu_stall=1.
- HOLD:
  - ifu_stall=1 while backend_stall=1.
  - A new ex_br_valid overwrites a pending JAL. A pending execute redirect overwrites itself only with a newer execute redirect. dec_jal_valid is ignored.
  - When backend_stall=0: drive the pending redirect, pulse redirect_taken, clear pending, enter SQUASH (or RUN if SQUASH_CYCLES=0).
- SQUASH:
  - fetch_valid=0. dec_jal_valid is ignored because decode is seeing the wrong path.
  - The counter decrements only on cycles with backend_stall=0. At 1 with no stall, the next state is RUN.
  - ex_br_valid in SQUASH is handled as in RUN: applied immediately if not stalled, otherwise goes to HOLD. The counter reloads when the redirect is applied.
- fetch_valid=1 only in RUN. It is 0 in HOLD and SQUASH.
- Counter width: $clog2(SQUASH_CYCLES+1), minimum 1.
- Reset (asynchronous, at any time including mid-HOLD or mid-SQUASH): state=RUN, pending cleared, counter=0. The next cycle drives the default outputs with fetch_valid=1.

## Timing
- Request to IFU PC load: 0 cycles of controller latency when not stalled. The request in cycle N updates the PC at the end of cycle N.
- Redirect while stalled: applied in the first cycle backend_stall is low. Worst case is the stall duration plus 0.
- Squash: exactly SQUASH_CYCLES unstalled cycles with fetch_valid=0 after each applied redirect.
- redirect_taken is high exactly once per applied redirect.
- There is no combinational path from backend_stall to next_pc_sel other than the pending-drive decision.

## Structure
- Shared package holds:
  - the next_pc_t enum (sb, uj, jalr, pc_plus_4_t), which is shared with the IFU
  - the state enum (RUN, HOLD, SQUASH)
  - the pending-redirect struct {valid, kind, target}
- No sub-modules: the state register, pending register and squash counter sit in one module.

## Test plan
- RUN, ex_br_valid=1, ex_br_is_jalr=0, ex_br_target=0x40, no stall -> same cycle: next_pc_sel=sb, SB_Type_addr=0x40, redirect_taken=1; next cycle fetch_valid=0; following cycle fetch_valid=1.
- dec_jal_valid (target 0x80) and ex_br_valid JALR (target 0x100) in the same cycle -> jalr selected, JALR_Type_addr=0x100, UJ_Type_addr=0, JAL dropped.
- dec_jal_valid (target 0x200) with backend_stall=1 for 3 cycles -> ifu_stall=1 and fetch_valid=0 for 3 cycles; in the 4th cycle next_pc_sel=uj, UJ_Type_addr=0x200, redirect_taken=1.
- HOLD with pending JAL 0x200, then ex_br_valid branch to 0x300 while still stalled -> on release sb with SB_Type_addr=0x300; exactly one redirect_taken pulse.
- SQUASH_CYCLES=2, redirect followed by backend_stall=1 for 2 cycles -> fetch_valid stays 0 for 2 unstalled cycles after the stall clears.
- Assert reset mid-HOLD -> outputs return to defaults immediately; the pending redirect is never driven after reset is released.
